// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed big-endian byte stream and writes it
// word-by-word into instruction memory at TEXT_BASE, holding the CPU in reset
// until the image is complete. Define PROGRAM_LOADER_CHECKSUM_EN to require a
// trailing XOR checksum byte after the last word.
module program_loader #(
    parameter int                    MEMORY_DEPTH = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t S_FIN = S_CHK;
`else
    localparam state_t S_FIN = S_DONE;
`endif

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           idx_q, idx_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [23:0]           word_q, word_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic        accept;
    logic [15:0] len_n;

    assign accept = byte_valid && byte_ready;
    assign len_n  = {len_q[15:8], byte_data};

    // state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // next-state logic: length decode, 4-byte word assembly, write sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = start ? S_LEN_HI : S_IDLE;
            S_LEN_HI: state_d = accept ? S_LEN_LO : S_LEN_HI;
            S_LEN_LO: if (accept) state_d = (len_n == 16'd0) ? S_FIN :
                                            (len_n > 16'(MEMORY_DEPTH)) ? S_ERR : S_DATA;
            S_DATA:   state_d = (accept && cnt_q == 2'd3) ? S_WRITE : S_DATA;
            S_WRITE:  state_d = (idx_q + 16'd1 == len_q) ? S_FIN : S_DATA;
            S_DONE,
            S_ERR:    state_d = start ? S_LEN_HI : state_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHK:    if (accept) state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    // datapath next values: length latch, byte shifter, write address/data capture
    always_comb begin
        len_d  = len_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        word_d = word_q;
        addr_d = addr_q;
        data_d = data_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d = csum_q;
`endif
        if (accept && state_q == S_LEN_HI) len_d[15:8] = byte_data;
        if (accept && state_q == S_LEN_LO) begin
            len_d[7:0] = byte_data;
            idx_d      = '0;
            cnt_d      = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_d     = '0;
`endif
        end
        if (accept && state_q == S_DATA) begin
            word_d = {word_q[15:0], byte_data};
            cnt_d  = cnt_q + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_d = csum_q ^ byte_data;
`endif
            if (cnt_q == 2'd3) begin
                data_d = DATA_WIDTH'({word_q, byte_data});
                addr_d = TEXT_BASE + (DATA_WIDTH'(idx_q) << 2);
            end
        end
        if (state_q == S_WRITE) idx_d = idx_q + 16'd1;
    end

    // datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q  <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            word_q <= '0;
            addr_q <= TEXT_BASE;
            data_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q <= '0;
`endif
        end else begin
            len_q  <= len_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            word_q <= word_d;
            addr_q <= addr_d;
            data_q <= data_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q <= csum_d;
`endif
        end
    end

    // outputs decoded from state; address/data hold between writes
    always_comb begin
        byte_ready  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        byte_ready  = byte_ready || (state_q == S_CHK);
`endif
        mem_we      = state_q == S_WRITE;
        mem_address = addr_q;
        mem_data    = data_q;
        done        = state_q == S_DONE;
        error       = state_q == S_ERR;
        cpu_hold    = state_q != S_DONE;
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed load scenarios checked against a stream-level model of expected writes and final status
module tb_program_loader;

    localparam int          DEPTH = 32;
    localparam logic [31:0] BASE  = 32'h0040_0000;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready, mem_we, cpu_hold, done, error;
    logic [31:0] mem_address, mem_data;

    int n_assert = 0;
    int n_fail   = 0;
    bit stray_start = 1'b0;

    logic [31:0] words [0:63];
    logic [31:0] exp_addr[$], exp_data[$], log_addr[$], log_data[$];

    program_loader #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32), .TEXT_BASE(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .mem_we(mem_we), .mem_address(mem_address), .mem_data(mem_data),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // every-cycle compare against the model's expected write list and status invariants
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_addr.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_address, mem_data);
            end else begin
                chk("wr_addr", mem_address, exp_addr.pop_front());
                chk("wr_data", mem_data, exp_data.pop_front());
            end
            log_addr.push_back(mem_address);
            log_data.push_back(mem_data);
        end
        chk("hold_vs_done", 32'(cpu_hold), 32'(!done));
        chk("ready_in_final", 32'(byte_ready && (done || error)), 32'd0);
        chk("done_err_excl", 32'(done && error), 32'd0);
    end

    // called at a negedge; returns at the negedge after the byte was taken
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t = 0;
        if (gap) begin
            byte_valid = 1'b0;
            start = stray_start;
            @(negedge clk);
            start = 1'b0;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready) begin
            n_assert++;
            n_fail++;
            $display("FAIL byte_timeout: got byte_ready=0 expected 1 within 50 cycles");
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic run_load(input logic [15:0] n, input bit gap, input bit bad, input bit sim);
        logic [7:0] x = 8'h00;
        bit ee;
        log_addr.delete();
        log_data.delete();
        ee = (n > DEPTH);
        if (!ee) begin
            for (int i = 0; i < int'(n); i++) begin
                exp_addr.push_back(BASE + 32'(4 * i));
                exp_data.push_back(words[i]);
                x = x ^ words[i][31:24] ^ words[i][23:16] ^ words[i][15:8] ^ words[i][7:0];
            end
        end
        ee = ee || (bad && CHK_ON);
        if (sim) begin
            byte_valid = 1'b1;
            byte_data  = n[15:8];
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(n[15:8], 1'b0);
        send_byte(n[7:0], gap);
        if (n <= DEPTH) begin
            for (int i = 0; i < int'(n); i++) begin
                for (int j = 0; j < 4; j++) begin
                    send_byte(words[i][31-8*j -: 8], gap);
                    if (j == 3) chk("we_latency", 32'(mem_we), 32'd1);
                end
            end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (n <= DEPTH) send_byte(x ^ {7'd0, bad}, gap);
`else
        if (n != 0 && n <= DEPTH) @(negedge clk);
`endif
        chk("final_done", 32'(done), 32'(!ee));
        chk("final_error", 32'(error), 32'(ee));
        chk("final_hold", 32'(cpu_hold), 32'(ee));
        chk("final_ready", 32'(byte_ready), 32'd0);
        @(negedge clk);
        chk("pending_writes", 32'(exp_addr.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before 300000");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_addr", mem_address, 32'h0040_0000);
        chk("rst_data", mem_data, 32'h0000_0000);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        reset = 1'b0;
        byte_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", 32'(byte_ready), 32'd0);
        chk("idle_hold", 32'(cpu_hold), 32'd1);
        byte_valid = 1'b0;

        // two-word image, start coincident with a valid byte
        words[0] = 32'h2008_0005;
        words[1] = 32'h0109_5020;
        run_load(16'h0002, 1'b0, 1'b0, 1'b1);
        chk("t1_nwr", 32'(log_addr.size()), 32'd2);
        chk("t1_a0", log_addr[0], 32'h0040_0000);
        chk("t1_d0", log_data[0], 32'h2008_0005);
        chk("t1_a1", log_addr[1], 32'h0040_0004);
        chk("t1_d1", log_data[1], 32'h0109_5020);

        // oversize length then recovery
        run_load(16'h0021, 1'b0, 1'b0, 1'b0);
        chk("t2_nwr", 32'(log_addr.size()), 32'd0);
        chk("t2_err", 32'(error), 32'd1);
        words[0] = 32'hAABB_CCDD;
        run_load(16'h0001, 1'b0, 1'b0, 1'b0);
        chk("t2b_err", 32'(error), 32'd0);
        chk("t2b_d0", log_data[0], 32'hAABB_CCDD);
        chk("t2b_a0", log_addr[0], 32'h0040_0000);

        // gapped valid with stray start pulses mid-load
        stray_start = 1'b1;
        words[0] = 32'h5A3C_96E1;
        run_load(16'h0001, 1'b1, 1'b0, 1'b0);
        stray_start = 1'b0;
        chk("t3_nwr", 32'(log_addr.size()), 32'd1);
        chk("t3_d0", log_data[0], 32'h5A3C_96E1);

        // reset after two data bytes
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_we", 32'(mem_we), 32'd0);
        chk("mid_ready", 32'(byte_ready), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_addr", mem_address, 32'h0040_0000);
        chk("mid_data", mem_data, 32'h0000_0000);
        chk("mid_hold", 32'(cpu_hold), 32'd1);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_idle_ready", 32'(byte_ready), 32'd0);
        words[0] = 32'hCAFE_F00D;
        run_load(16'h0001, 1'b0, 1'b0, 1'b0);
        chk("t4_a0", log_addr[0], 32'h0040_0000);
        chk("t4_d0", log_data[0], 32'hCAFE_F00D);

        // empty image
        run_load(16'h0000, 1'b0, 1'b0, 1'b0);
        chk("t5_nwr", 32'(log_addr.size()), 32'd0);

        // full-depth image
        for (int i = 0; i < DEPTH; i++) words[i] = (32'h0102_0304 * 32'(i + 1)) ^ 32'(i << 20);
        run_load(16'h0020, 1'b0, 1'b0, 1'b0);
        chk("t6_nwr", 32'(log_addr.size()), 32'd32);
        chk("t6_last_addr", log_addr[31], 32'h0040_007C);

        // checksum byte 08 for 12 34 56 78; a corrupted checksum still writes
        words[0] = 32'h1234_5678;
        run_load(16'h0001, 1'b0, 1'b0, 1'b0);
        chk("t7_d0", log_data[0], 32'h1234_5678);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        run_load(16'h0001, 1'b0, 1'b1, 1'b0);
        chk("t7b_err", 32'(error), 32'd1);
        chk("t7b_d0", log_data[0], 32'h1234_5678);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
